inv_cipher_ctrl: RTL
====================

# inv_cipher_ctrl

Iterative AES-128 decryption sequencer. It accepts one 128-bit ciphertext block through a valid/ready handshake and performs the initial AddRoundKey internally. It then drives a shared inverse-round datapath for rounds 9..1 (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) and a final-round datapath for round 0 (InvShiftRows, InvSubBytes, AddRoundKey). It fetches round keys from an external key table by index and returns the plaintext through a second valid/ready handshake.

## Interface
Parameters:
- NR, 10, number of rounds; fixed for AES-128, only 10 is supported.
- KIDX_W, 4, width of the round-key index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  ciphertext block present.
- in_ready  output  1  controller can accept a block.
- in_data  input  [0:127]  ciphertext; bit 0 is the MSB of byte 0.
- out_valid  output  1  plaintext block present.
- out_ready  input  1  consumer accepts plaintext.
- out_data  output  [0:127]  plaintext; it is the state register.
- key_idx  output  KIDX_W  round-key index requested this cycle (0..10).
- key_word  input  [0:127]  round key for key_idx; must be valid combinationally in the same cycle.
- dp_state  output  [0:127]  state fed to both datapaths; it is the state register.
- dp_key  output  [0:127]  key fed to both datapaths; it is key_word passed through.
- dp_round_in  input  [0:127]  inverse-round datapath result for (dp_state, dp_key).
- dp_final_in  input  [0:127]  final-round datapath result for (dp_state, dp_key).
- busy  output  1  high in ROUND and FINAL.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- Registers: state[0:127], rnd[3:0].
- IDLE:
  - in_ready=1, key_idx=10.
  - On in_valid, at the edge: state <= in_data ^ key_word, rnd <= 9, go to ROUND.
- ROUND:
  - key_idx=rnd.
  - Each edge: state <= dp_round_in.
  - If rnd==1: go to FINAL. Otherwise rnd <= rnd-1.
- FINAL:
  - key_idx=0.
  - At the edge: state <= dp_final_in, go to DONE.
- DONE:
  - out_valid=1, key_idx=0.
  - state holds while out_ready=0.
  - On out_ready, at the edge: go to IDLE.
- in_ready=1 only in IDLE. in_valid in any other state is ignored and not captured.
- out_data and dp_state are always the state register. A consumer must sample out_data only while out_valid=1.
- dp_key = key_word in every state. The datapaths are purely combinational; the controller adds no register stage between them.
- No XOR or key arithmetic except the initial ARK. All round math lives in the datapaths.
- rnd never leaves 1..9 while in ROUND. rnd is don't-care in other states but is held, not reset, between blocks.

## Timing
- Reset (rst_n=0, asynchronous):
  - FSM=IDLE, state=0, rnd=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, key_idx=10, out_data=0.
- Reset asserted mid-operation aborts the block immediately. No out_valid is produced for that block.
- Release of rst_n is synchronized externally. The first accept is possible on the first edge after release.
- Latency: with the accept at edge E, out_valid rises after edge E+10 (9 ROUND edges plus 1 FINAL edge).
- out_valid stays high until the edge where out_ready=1. It falls in the following cycle.
- Throughput with out_ready tied high: one block every 12 cycles (accept, 9 rounds, final, DONE).
- in_ready returns to 1 in the cycle after the DONE handshake. There is no same-cycle accept and output overlap.
- key_word is read in the same cycle as key_idx. A registered key table must present key_word with zero latency relative to key_idx, or key_idx must be used as a look-ahead outside this block.
- Back-pressure: out_ready low for N cycles extends DONE by N cycles. state and out_data are stable during the stall.

## Test plan
- FIPS-197 C.1: key table built from key 000102030405060708090a0b0c0d0e0f, in_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1.
  - Expect state=7ad5fda789ef4e272bca100b3d9ff59f after the accept edge.
  - Expect out_data=00112233445566778899aabbccddeeff with out_valid rising exactly 10 edges after accept.
- key_idx sequence check on the same vector: 10 at accept, then 9,8,...,1 in ROUND, 0 in FINAL; busy high for exactly 10 cycles.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid and out_data stay stable.
  - in_ready stays 0; in_valid pulses are ignored.
  - The release yields one transfer.
- Back-to-back: two blocks with in_valid held high and out_ready=1. Both plaintexts are correct and the accepts are 12 cycles apart.
- Reset abort: assert rst_n=0 at ROUND rnd=5.
  - Outputs reach their reset values without a clock edge.
  - No out_valid is produced.
  - The next block decrypts correctly.
- Ignored input: pulse in_valid with a different in_data during ROUND. The result equals that of the originally accepted block.

Source files
------------

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES-128 decryption sequencer: initial AddRoundKey here, rounds 9..1 and round 0
// are computed by external combinational datapaths that this block drives and captures.
module inv_cipher_ctrl #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:127]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:127]      out_data,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [0:127]      key_word,
  output logic [0:127]      dp_state,
  output logic [0:127]      dp_key,
  input  logic [0:127]      dp_round_in,
  input  logic [0:127]      dp_final_in,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for a ciphertext block, key_idx points at the last round key
  // ROUND | inverse rounds rnd = 9..1 through the shared round datapath
  // FINAL | round 0 through the final-round datapath
  // DONE  | plaintext held in the state register until out_ready
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm_q, fsm_nxt;
  logic [0:127] state_q, state_nxt;
  logic [3:0]   rnd_q, rnd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_nxt;
      state_q <= state_nxt;
      rnd_q   <= rnd_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm_q;
    state_nxt = state_q;
    rnd_nxt   = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    key_idx   = '0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        key_idx  = KIDX_W'(NR);
        if (in_valid) begin
          state_nxt = in_data ^ key_word;
          rnd_nxt   = 4'(NR - 1);
          fsm_nxt   = ROUND;
        end
      end
      ROUND: begin
        busy      = 1'b1;
        key_idx   = KIDX_W'(rnd_q);
        state_nxt = dp_round_in;
        if (rnd_q == 4'd1) fsm_nxt = FINAL;
        else               rnd_nxt = rnd_q - 4'd1;
      end
      FINAL: begin
        busy      = 1'b1;
        state_nxt = dp_final_in;
        fsm_nxt   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // The datapaths see the live state and key; no extra pipeline stage in between.
  assign dp_state = state_q;
  assign out_data = state_q;
  assign dp_key   = key_word;

endmodule
